// File: rtl/mcu_spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcu_spi_pkg : target ids, frame FSM states and target decode helper      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mcu_spi_pkg;

  localparam logic [7:0] TGT_SYS = 8'd0;
  localparam logic [7:0] TGT_HID = 8'd1;
  localparam logic [7:0] TGT_OSD = 8'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TGT     = 2'd1,
    FIRST   = 2'd2,
    PAYLOAD = 2'd3
  } spi_state_e;

  // One-hot {osd, hid, sys}; ids at or beyond num_tgt select nothing.
  function automatic logic [2:0] tgt_decode(input logic [7:0] tgt, input logic [7:0] num_tgt);
    logic [2:0] oh;
    oh = 3'b000;
    if (tgt < num_tgt) begin
      case (tgt)
        TGT_SYS: oh = 3'b001;
        TGT_HID: oh = 3'b010;
        TGT_OSD: oh = 3'b100;
        default: oh = 3'b000;
      endcase
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_sync_edge : pin synchroniser with rise/fall pulses on the edge pin,  |
// |                 plus plain level synchronisation for auxiliary pins      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter int AUX_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pin_i,
  input  logic [AUX_W-1:0] aux_i,
  output logic [AUX_W-1:0] aux_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [STAGES-1:0]            edge_q;
  logic                         prev_q;
  logic [STAGES-1:0][AUX_W-1:0] aux_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q <= '0;
      prev_q <= 1'b0;
      aux_q  <= '0;
    end else begin
      edge_q <= {edge_q[STAGES-2:0], pin_i};
      prev_q <= edge_q[STAGES-1];
      aux_q  <= {aux_q[STAGES-2:0], aux_i};
    end
  end

  assign aux_o  = aux_q[STAGES-1];
  assign rise_o = edge_q[STAGES-1] & ~prev_q;
  assign fall_o = ~edge_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/mcu_spi_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcu_spi_frontend : oversampled SPI slave routing MCU frames to targets   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mcu_spi_frontend
  import mcu_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_TGT     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic [7:0] data_out,
  output logic       data_start,
  output logic       sys_strobe,
  output logic       hid_strobe,
  output logic       osd_strobe,
  input  logic [7:0] sys_din,
  input  logic [7:0] hid_din,
  input  logic [7:0] osd_din
);

  localparam logic [7:0] NUM_TGT_B = 8'(NUM_TGT);

  logic [1:0] w_aux_s;
  logic       w_ss_s, w_mosi_s;
  logic       w_sck_rise_raw, w_sck_fall_raw;
  logic       w_sck_rise, w_sck_fall;
  logic [2:0] w_tgt_oh;
  logic [7:0] w_reply;

  spi_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] tgt_q, tgt_d;
  logic [7:0] data_q, data_d;
  logic [2:0] strobe_q, strobe_d;
  logic       start_q, start_d;
  logic       byte_done_q, byte_done_d;
  logic       ss_prev_q;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .AUX_W  (2)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (spi_io_clk),
    .aux_i  ({spi_io_din, spi_io_ss}),
    .aux_o  (w_aux_s),
    .rise_o (w_sck_rise_raw),
    .fall_o (w_sck_fall_raw)
  );

  assign w_ss_s     = w_aux_s[0];
  assign w_mosi_s   = w_aux_s[1];
  assign w_sck_rise = w_sck_rise_raw & ~w_ss_s;
  assign w_sck_fall = w_sck_fall_raw & ~w_ss_s;

  assign w_tgt_oh = tgt_decode(tgt_q, NUM_TGT_B);

  // Reply only once a target is latched; unknown ids decode to no select.
  always_comb begin
    w_reply = 8'h00;
    if (state_q == FIRST || state_q == PAYLOAD) begin
      w_reply = ({8{w_tgt_oh[0]}} & sys_din)
              | ({8{w_tgt_oh[1]}} & hid_din)
              | ({8{w_tgt_oh[2]}} & osd_din);
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    tgt_d       = tgt_q;
    data_d      = data_q;
    strobe_d    = 3'b000;
    start_d     = 1'b0;
    byte_done_d = 1'b0;
    if (w_ss_s) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
      tx_d      = 8'h00;
    end else begin
      if (w_sck_rise) begin
        rx_d        = {rx_q[6:0], w_mosi_s};
        bit_cnt_d   = bit_cnt_q + 3'd1;
        byte_done_d = (bit_cnt_q == 3'd7);
      end
      if (w_sck_fall) begin
        tx_d = (bit_cnt_q == 3'd0) ? w_reply : {tx_q[6:0], 1'b0};
      end
      case (state_q)
        // ss is low here, so a high previous sample marks the falling edge
        IDLE: if (ss_prev_q) state_d = TGT;
        TGT: begin
          if (byte_done_q) begin
            tgt_d   = rx_q;
            state_d = FIRST;
          end
        end
        FIRST, PAYLOAD: begin
          if (byte_done_q) begin
            data_d   = rx_q;
            strobe_d = w_tgt_oh;
            start_d  = (state_q == FIRST) && (|w_tgt_oh);
            state_d  = PAYLOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      tgt_q       <= 8'h00;
      data_q      <= 8'h00;
      strobe_q    <= 3'b000;
      start_q     <= 1'b0;
      byte_done_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      tgt_q       <= tgt_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      start_q     <= start_d;
      byte_done_q <= byte_done_d;
      ss_prev_q   <= w_ss_s;
    end
  end

  assign spi_io_dout = tx_q[7];
  assign data_out    = data_q;
  assign data_start  = start_q;
  assign sys_strobe  = strobe_q[0];
  assign hid_strobe  = strobe_q[1];
  assign osd_strobe  = strobe_q[2];

endmodule
`default_nettype wire
